axis_tx_frame_gen: RTL and testbench
====================================

# axis_tx_frame_gen

Parametrised AXI-Stream frame generator, successor of `axis_tx_buffer`, used as the SFP-side stimulus source in f9pcap benches and board bring-up images. It replays a byte pattern as one or more frames of runtime-selectable length. It supports per-frame sequence stamping, a programmable inter-frame gap, a repeat count, a stop request and `tx_ready_in` backpressure. It sits directly on an `sfp_rx_*` style AXIS input of the capture path.

## Interface
- `TX_BUF_LENGTH`, 64: pattern buffer size in bytes; maximum frame length.
- `OUT_DATA_WIDTH`, 64: AXIS data width in bits; a multiple of `BYTE_WIDTH`.
- `LEN_WIDTH`, `$clog2(TX_BUF_LENGTH+1)`: width of the frame-length config.
- `GAP_WIDTH`, 16: width of the inter-frame gap config.
- `CNT_WIDTH`, 16: width of the repeat count and the frame counter.
- `SEQ_BYTES`, 0: number of leading frame bytes (0..8) overwritten with the frame index, little-endian; 0 disables stamping.

Ports:
- `clk_in` in 1: the only clock; all logic is on its rising edge.
- `rst_n_in` in 1: reset, asynchronous and active-low.
- `tx_buf_in` in `TX_BUF_LENGTH*BYTE_WIDTH`: pattern; byte 0 is in bits [7:0].
- `cfg_len_in` in `LEN_WIDTH`: frame length in bytes.
- `cfg_gap_in` in `GAP_WIDTH`: idle cycles between frames.
- `cfg_count_in` in `CNT_WIDTH`: frames per run; 0 means run until stopped.
- `start_in` in 1: start request, level-sampled.
- `stop_in` in 1: stop request, level-sampled.
- `tx_valid_out` out 1: AXIS valid.
- `tx_ready_in` in 1: AXIS ready.
- `tx_data_out` out `OUT_DATA_WIDTH`: AXIS data.
- `tx_keep_out` out `OUT_DATA_WIDTH/BYTE_WIDTH`: AXIS keep.
- `tx_last_out` out 1: AXIS last.
- `busy_out` out 1: high while a run is active.
- `frame_cnt_out` out `CNT_WIDTH`: frames completed in the current run.

## Operation
- States: IDLE, SEND, GAP.
- **IDLE, `start_in` high:** snapshot `tx_buf_in`, `cfg_len_in`, `cfg_gap_in` and `cfg_count_in`. Clear `frame_cnt_out`. Go to SEND.
- **IDLE otherwise:** `start_in` is ignored while busy; `stop_in` is ignored in IDLE.
- **Length rules:** effective length L = `cfg_len_in`. L = 0 or L > `TX_BUF_LENGTH` is clamped to `TX_BUF_LENGTH`. L < `SEQ_BYTES` is raised to `SEQ_BYTES`.
- **Beat layout:** N = `OUT_DATA_WIDTH/BYTE_WIDTH`. Beat k carries bytes k*N .. k*N+N-1 with byte k*N on lane 0. Beats per frame = ceil(L/N).
- **Keep:** full on every beat except the last. The last beat's keep has its low (L mod N, or N when the remainder is 0) bits set. Lanes with keep low carry 0.
- **Sequence stamp:** bytes 0..`SEQ_BYTES`-1 of each frame are `frame_cnt_out` zero-extended, little-endian.
- **SEND:** the beat advances only on `tx_valid_out && tx_ready_in`.
- **Last handshake:** `frame_cnt_out` increments, wrapping at 2^`CNT_WIDTH`. Then:
  - Run ends (count reached, or stop pending) -> IDLE.
  - Else if gap > 0 -> GAP.
  - Else next frame, beat 0.
- **GAP:** counts `cfg_gap` cycles with `tx_valid_out` low, then returns to SEND.
- **Stop:** `stop_in` sampled high in SEND sets `stop_pend`. The current frame always completes and is never truncated. `stop_in` in GAP -> IDLE on the next edge.
- **Start and stop together in IDLE:** start wins, and the stop is ignored.
- **Reset mid-frame:** all state is cleared immediately. No `tx_last_out` is emitted for the aborted frame.

## Timing
- **Reset values:** `tx_valid_out`=0, `tx_data_out`=0, `tx_keep_out`=0, `tx_last_out`=0, `busy_out`=0, `frame_cnt_out`=0.
- **Start latency:** `start_in` sampled at edge t gives `tx_valid_out`=1 with beat 0 after edge t, and `busy_out`=1 in the same cycle.
- **Output stability:** all outputs are registered. Data, keep and last hold stable while valid is high and ready is low. Valid never drops without a handshake.
- **Back-to-back:** with gap 0, beat 0 of the next frame is presented the cycle after the last handshake.
- **With gap G:** exactly G cycles have valid low between the last handshake and the next beat 0. No gap is inserted after the final frame.
- **Run end:** `busy_out` drops the cycle after the final last-handshake, together with `tx_valid_out`.
- **Throughput:** one beat per cycle with `tx_ready_in` held high.

## Structure
- Package `axis_tx_gen_pkg` holds:
  - the state enum (IDLE/SEND/GAP);
  - function `keep_for_bytes(n)`;
  - function `beats_for_len(L, N)`.
- No sub-module; the beat mux is an indexed part-select on the snapshot register.

## Test plan
- **Single frame:** N=8, L=64, count=1, gap 0, ready=1, pattern 0x00..0x3f -> 8 beats. Beat 0 = 0x0706050403020100; keep=0xff on all beats; last on beat 7; `busy_out` low one cycle later; `frame_cnt_out`=1.
- **Partial last beat:** L=61 -> 8 beats, last keep=0x1f, lanes 5..7 zero.
- **Repeat with gap:** count=3, gap=5, `SEQ_BYTES`=2 -> frames start with bytes 00 00, 01 00, 02 00. Exactly 5 idle cycles between frames and none after the third; `frame_cnt_out`=3.
- **Backpressure:** random `tx_ready_in` (50%) -> data, keep and last stable during every stall. The byte stream is identical to the ready=1 run.
- **Stop:**
  - Count=0, `stop_in` pulsed mid-frame 2 -> frame 2 completes and the run stops; `frame_cnt_out`=3 (frames 0..2).
  - `stop_in` during GAP -> no further valid.
- **Reset and clamping:**
  - `rst_n_in` low mid-frame -> all outputs 0 asynchronously.
  - A new start after release emits beat 0.
  - `cfg_len_in`=0 -> 64-byte frame.

Source files
------------

// File: rtl/axis_tx_gen_pkg.sv
// Shared types and helpers for the AXI-Stream frame generator.
package axis_tx_gen_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    // Lane mask with the low n bits set; callers truncate to their lane count.
    function automatic logic [63:0] keep_for_bytes(input int n);
        logic [63:0] k;
        k = '0;
        for (int i = 0; i < 64; i++) begin
            k[i] = (i < n);
        end
        return k;
    endfunction

    function automatic int beats_for_len(input int len, input int n);
        return (len + n - 1) / n;
    endfunction

endpackage

// File: rtl/axis_tx_frame_gen.sv
// Replays a snapshotted byte pattern as AXI-Stream frames with optional
// sequence stamping, inter-frame gap, repeat count and stop request.
module axis_tx_frame_gen
    import axis_tx_gen_pkg::*;
#(
    parameter int TX_BUF_LENGTH  = 64,
    parameter int OUT_DATA_WIDTH = 64,
    parameter int LEN_WIDTH      = $clog2(TX_BUF_LENGTH + 1),
    parameter int GAP_WIDTH      = 16,
    parameter int CNT_WIDTH      = 16,
    parameter int SEQ_BYTES      = 0
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic [TX_BUF_LENGTH*BYTE_WIDTH-1:0]  tx_buf_in,
    input  logic [LEN_WIDTH-1:0]                 cfg_len_in,
    input  logic [GAP_WIDTH-1:0]                 cfg_gap_in,
    input  logic [CNT_WIDTH-1:0]                 cfg_count_in,
    input  logic                                 start_in,
    input  logic                                 stop_in,
    output logic                                 tx_valid_out,
    input  logic                                 tx_ready_in,
    output logic [OUT_DATA_WIDTH-1:0]            tx_data_out,
    output logic [OUT_DATA_WIDTH/BYTE_WIDTH-1:0] tx_keep_out,
    output logic                                 tx_last_out,
    output logic                                 busy_out,
    output logic [CNT_WIDTH-1:0]                 frame_cnt_out,
    output logic [1:0]                           state_dbg_out
);

    localparam int N         = OUT_DATA_WIDTH / BYTE_WIDTH;
    localparam int MAX_BEATS = (TX_BUF_LENGTH + N - 1) / N;
    localparam int PAD_W     = MAX_BEATS * OUT_DATA_WIDTH;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int LANE_W    = $clog2(N + 1);

    tx_state_e              state_q, state_d;
    logic [PAD_W-1:0]       buf_q, buf_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [BEAT_W-1:0]      last_beat_q, last_beat_d;
    logic [LANE_W-1:0]      last_bytes_q, last_bytes_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic                   stop_pend_q, stop_pend_d;

    logic                   valid_q, valid_d;
    logic [OUT_DATA_WIDTH-1:0] data_q, data_d;
    logic [N-1:0]           keep_q, keep_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;

    logic                   hs;
    int                     len_eff;
    int                     beats_eff;
    int                     byte_idx;
    logic [OUT_DATA_WIDTH-1:0] beat_word;

    // A beat transfers on a rising edge where valid and ready are both high;
    // once valid is raised, data/keep/last are frozen until that transfer.
    assign hs = valid_q && tx_ready_in;

    always_comb begin
        len_eff = int'(cfg_len_in);
        if (len_eff == 0 || len_eff > TX_BUF_LENGTH) len_eff = TX_BUF_LENGTH;
        if (len_eff < SEQ_BYTES) len_eff = SEQ_BYTES;
        beats_eff = beats_for_len(len_eff, N);
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        beat_d       = beat_q;
        last_beat_d  = last_beat_q;
        last_bytes_d = last_bytes_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        count_d      = count_q;
        frame_cnt_d  = frame_cnt_q;
        stop_pend_d  = stop_pend_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d      = SEND;
                    buf_d        = PAD_W'(tx_buf_in);
                    beat_d       = '0;
                    last_beat_d  = BEAT_W'(beats_eff - 1);
                    last_bytes_d = LANE_W'(len_eff - (beats_eff - 1) * N);
                    gap_d        = cfg_gap_in;
                    count_d      = cfg_count_in;
                    frame_cnt_d  = '0;
                    stop_pend_d  = 1'b0;
                end
            end
            SEND: begin
                if (stop_in) stop_pend_d = 1'b1;
                if (hs) begin
                    if (beat_q == last_beat_q) begin
                        frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                        beat_d      = '0;
                        if ((count_q != '0 && frame_cnt_d == count_q) || stop_pend_d) begin
                            state_d = IDLE;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            GAP: begin
                if (stop_in) begin
                    state_d = IDLE;
                end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from next-state values so the registered beat
    // appears the cycle after start or handshake.
    always_comb begin
        valid_d   = 1'b0;
        data_d    = '0;
        keep_d    = '0;
        last_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        beat_word = '0;
        byte_idx  = 0;
        if (state_d == SEND) begin
            valid_d   = 1'b1;
            beat_word = buf_d[beat_d*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
            if (beat_d == last_beat_d) begin
                last_d = 1'b1;
                keep_d = N'(keep_for_bytes(int'(last_bytes_d)));
            end else begin
                keep_d = '1;
            end
            for (int j = 0; j < N; j++) begin
                byte_idx = int'(beat_d) * N + j;
                if (byte_idx < SEQ_BYTES) begin
                    data_d[j*BYTE_WIDTH +: BYTE_WIDTH] =
                        BYTE_WIDTH'(frame_cnt_d >> (byte_idx * BYTE_WIDTH));
                end else if (keep_d[j]) begin
                    data_d[j*BYTE_WIDTH +: BYTE_WIDTH] = beat_word[j*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            beat_q       <= '0;
            last_beat_q  <= '0;
            last_bytes_q <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            count_q      <= '0;
            frame_cnt_q  <= '0;
            stop_pend_q  <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            beat_q       <= beat_d;
            last_beat_q  <= last_beat_d;
            last_bytes_q <= last_bytes_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            count_q      <= count_d;
            frame_cnt_q  <= frame_cnt_d;
            stop_pend_q  <= stop_pend_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_valid_out  = valid_q;
    assign tx_data_out   = data_q;
    assign tx_keep_out   = keep_q;
    assign tx_last_out   = last_q;
    assign busy_out      = busy_q;
    assign frame_cnt_out = frame_cnt_q;
    assign state_dbg_out = state_q;

endmodule

// File: tb/tb_axis_tx_frame_gen.sv
// Bench for axis_tx_frame_gen: one unstamped and one 2-byte-stamped instance
// share stimulus; a beat model feeds per-instance expected queues.
module tb_axis_tx_frame_gen;

    localparam int BUF_LEN = 64;
    localparam int DW      = 64;
    localparam int LW      = 7;
    localparam int GW      = 16;
    localparam int CW      = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [BUF_LEN*8-1:0] tx_buf = '0;
    logic [LW-1:0] cfg_len = '0;
    logic [GW-1:0] cfg_gap = '0;
    logic [CW-1:0] cfg_count = '0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic tx_ready = 1'b1;

    logic d0_valid, d0_last, d0_busy, d1_valid, d1_last, d1_busy;
    logic [DW-1:0] d0_data, d1_data;
    logic [7:0] d0_keep, d1_keep;
    logic [CW-1:0] d0_cnt, d1_cnt;
    logic [1:0] d0_state, d1_state;

    axis_tx_frame_gen #(.TX_BUF_LENGTH(BUF_LEN), .OUT_DATA_WIDTH(DW), .SEQ_BYTES(0)) u_dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .tx_buf_in(tx_buf), .cfg_len_in(cfg_len),
        .cfg_gap_in(cfg_gap), .cfg_count_in(cfg_count), .start_in(start), .stop_in(stop),
        .tx_valid_out(d0_valid), .tx_ready_in(tx_ready), .tx_data_out(d0_data),
        .tx_keep_out(d0_keep), .tx_last_out(d0_last), .busy_out(d0_busy),
        .frame_cnt_out(d0_cnt), .state_dbg_out(d0_state)
    );

    axis_tx_frame_gen #(.TX_BUF_LENGTH(BUF_LEN), .OUT_DATA_WIDTH(DW), .SEQ_BYTES(2)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .tx_buf_in(tx_buf), .cfg_len_in(cfg_len),
        .cfg_gap_in(cfg_gap), .cfg_count_in(cfg_count), .start_in(start), .stop_in(stop),
        .tx_valid_out(d1_valid), .tx_ready_in(tx_ready), .tx_data_out(d1_data),
        .tx_keep_out(d1_keep), .tx_last_out(d1_last), .busy_out(d1_busy),
        .frame_cnt_out(d1_cnt), .state_dbg_out(d1_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [72:0] exp_q0[$];
    logic [72:0] exp_q1[$];
    int n_checks = 0;
    int n_fail = 0;
    int gap_obs[$];
    bit gap_track = 1'b0;
    int idle_cnt = 0;
    int last_hs_cyc = -100;
    bit p0_stall = 1'b0;
    bit p1_stall = 1'b0;
    logic [72:0] p0_beat = '0;
    logic [72:0] p1_beat = '0;
    bit rand_ready = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected beats for both instances; instance 1 stamps 2 bytes
    task automatic push_run(input logic [BUF_LEN*8-1:0] pat, input int len_cfg, input int nframes);
        logic [63:0] dat;
        logic [7:0] kp;
        int len;
        int nb;
        int b;
        int seqb;
        for (int d = 0; d < 2; d++) begin
            seqb = (d == 0) ? 0 : 2;
            len = len_cfg;
            if (len == 0 || len > BUF_LEN) len = BUF_LEN;
            if (len < seqb) len = seqb;
            nb = (len + 7) / 8;
            for (int f = 0; f < nframes; f++) begin
                for (int k = 0; k < nb; k++) begin
                    dat = '0;
                    kp = '0;
                    for (int j = 0; j < 8; j++) begin
                        b = k * 8 + j;
                        if (b < len) begin
                            kp[j] = 1'b1;
                            if (b < seqb) dat[j*8 +: 8] = 8'((f >> (8 * b)) & 255);
                            else dat[j*8 +: 8] = pat[b*8 +: 8];
                        end
                    end
                    if (d == 0) exp_q0.push_back({dat, kp, (k == nb - 1)});
                    else exp_q1.push_back({dat, kp, (k == nb - 1)});
                end
            end
        end
    endtask

    // driver tasks
    task automatic start_run(input int len, input int gap, input int count, input bit with_stop);
        @(posedge clk);
        #1;
        cfg_len = LW'(len);
        cfg_gap = GW'(gap);
        cfg_count = CW'(count);
        start = 1'b1;
        stop = with_stop;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        check("start_busy", d0_busy, 1'b1);
        check("start_valid", d0_valid, 1'b1);
    endtask

    task automatic pulse_stop();
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int idle_at);
        idle_at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (d0_busy === 1'b0) begin
                idle_at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_cnt(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (d0_cnt == CW'(target)) break;
        end
    endtask

    // random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // monitor: stall stability, gap measurement, scoreboard compare
    always @(negedge clk) begin
        if (!rst_n) begin
            p0_stall = 1'b0;
            p1_stall = 1'b0;
            gap_track = 1'b0;
            idle_cnt = 0;
        end else begin
            if (p0_stall) check("stall_hold0", {d0_valid, d0_data, d0_keep, d0_last}, {1'b1, p0_beat});
            if (p1_stall) check("stall_hold1", {d1_valid, d1_data, d1_keep, d1_last}, {1'b1, p1_beat});
            if (gap_track) begin
                if (!d0_busy) gap_track = 1'b0;
                else if (d0_valid) begin
                    gap_obs.push_back(idle_cnt);
                    gap_track = 1'b0;
                end else idle_cnt++;
            end
            if (d0_valid && tx_ready) begin
                check("dut0_beat_expected", exp_q0.size() != 0, 1'b1);
                if (exp_q0.size() != 0) check("dut0_beat", {d0_data, d0_keep, d0_last}, exp_q0.pop_front());
                if (d0_last) begin
                    last_hs_cyc = cyc;
                    gap_track = 1'b1;
                    idle_cnt = 0;
                end
            end
            if (d1_valid && tx_ready) begin
                check("dut1_beat_expected", exp_q1.size() != 0, 1'b1);
                if (exp_q1.size() != 0) check("dut1_beat", {d1_data, d1_keep, d1_last}, exp_q1.pop_front());
            end
            p0_stall = d0_valid && !tx_ready;
            p1_stall = d1_valid && !tx_ready;
            p0_beat = {d0_data, d0_keep, d0_last};
            p1_beat = {d1_data, d1_keep, d1_last};
        end
    end

    logic [BUF_LEN*8-1:0] inc_pat;
    int idle_at;
    int valid_seen;

    initial begin
        for (int i = 0; i < BUF_LEN; i++) inc_pat[i*8 +: 8] = 8'(i);

        // reset state
        #12;
        check("rst_valid", d0_valid, 1'b0);
        check("rst_data", d0_data, 64'h0);
        check("rst_keep", d0_keep, 8'h0);
        check("rst_last", d0_last, 1'b0);
        check("rst_busy", d0_busy, 1'b0);
        check("rst_cnt", d0_cnt, 16'h0);
        check("rst_valid1", d1_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single full frame
        tx_buf = inc_pat;
        push_run(tx_buf, 64, 1);
        start_run(64, 0, 1, 1'b0);
        check("t1_beat0", d0_data, 64'h0706050403020100);
        wait_idle(100, idle_at);
        check("t1_end_cycle", idle_at, last_hs_cyc + 1);
        check("t1_valid_off", d0_valid, 1'b0);
        check("t1_cnt", d0_cnt, 16'd1);
        check("t1_q_empty", exp_q0.size() + exp_q1.size(), 0);

        // partial last beat
        push_run(tx_buf, 61, 1);
        start_run(61, 0, 1, 1'b0);
        wait_idle(100, idle_at);
        check("t2_end_cycle", idle_at, last_hs_cyc + 1);
        check("t2_q_empty", exp_q0.size() + exp_q1.size(), 0);

        // repeat with gap, stamped instance
        gap_obs.delete();
        push_run(tx_buf, 16, 3);
        start_run(16, 5, 3, 1'b0);
        check("t3_beat0_stamp", d1_data, 64'h0706050403020000);
        wait_idle(200, idle_at);
        check("t3_end_cycle", idle_at, last_hs_cyc + 1);
        check("t3_gap_count", gap_obs.size(), 2);
        for (int i = 0; i < gap_obs.size(); i++) check("t3_gap_len", gap_obs[i], 5);
        check("t3_cnt0", d0_cnt, 16'd3);
        check("t3_cnt1", d1_cnt, 16'd3);
        check("t3_q_empty", exp_q0.size() + exp_q1.size(), 0);

        // backpressure with random pattern
        for (int i = 0; i < BUF_LEN / 4; i++) tx_buf[i*32 +: 32] = $urandom();
        push_run(tx_buf, 61, 2);
        rand_ready = 1'b1;
        start_run(61, 2, 2, 1'b0);
        wait_idle(600, idle_at);
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        check("t4_idle_reached", idle_at >= 0, 1'b1);
        check("t4_cnt", d0_cnt, 16'd2);
        check("t4_q_empty", exp_q0.size() + exp_q1.size(), 0);

        // stop mid frame 2 of an endless run
        tx_buf = inc_pat;
        push_run(tx_buf, 64, 3);
        start_run(64, 0, 0, 1'b0);
        wait_cnt(2, 100);
        repeat (2) @(posedge clk);
        pulse_stop();
        wait_idle(100, idle_at);
        check("t5_end_cycle", idle_at, last_hs_cyc + 1);
        check("t5_cnt0", d0_cnt, 16'd3);
        check("t5_cnt1", d1_cnt, 16'd3);
        check("t5_q_empty", exp_q0.size() + exp_q1.size(), 0);

        // stop during gap
        push_run(tx_buf, 16, 1);
        start_run(16, 10, 0, 1'b0);
        wait_cnt(1, 50);
        pulse_stop();
        wait_idle(20, idle_at);
        check("t6_idle_reached", idle_at >= 0, 1'b1);
        valid_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (d0_valid || d1_valid) valid_seen++;
        end
        check("t6_no_valid", valid_seen, 0);
        check("t6_state_idle", d0_state, 2'd0);
        check("t6_cnt", d0_cnt, 16'd1);

        // asynchronous reset mid frame
        push_run(tx_buf, 64, 1);
        start_run(64, 0, 1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", d0_valid, 1'b0);
        check("t7_rst_data", d0_data, 64'h0);
        check("t7_rst_keep", d0_keep, 8'h0);
        check("t7_rst_last", d0_last, 1'b0);
        check("t7_rst_busy", d0_busy, 1'b0);
        check("t7_rst_valid1", d1_valid, 1'b0);
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // restart after reset with length 0 (clamped to buffer size)
        push_run(tx_buf, 0, 1);
        start_run(0, 0, 1, 1'b0);
        check("t8_beat0", d0_data, 64'h0706050403020100);
        wait_idle(100, idle_at);
        check("t8_end_cycle", idle_at, last_hs_cyc + 1);
        check("t8_cnt", d0_cnt, 16'd1);
        check("t8_q_empty", exp_q0.size() + exp_q1.size(), 0);

        // start and stop together: stop ignored
        push_run(tx_buf, 8, 2);
        start_run(8, 0, 2, 1'b1);
        wait_idle(100, idle_at);
        check("t9_cnt", d0_cnt, 16'd2);
        check("t9_q_empty", exp_q0.size() + exp_q1.size(), 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
